wb_arbiter: RTL and testbench

Shares the register file's single write port between several writeback sources: the pipeline writeback stage, the multdiv unit and other multi-cycle producers. The block arbitrates valid/ready requests, registers the winning address and data, and drives the register file write enable, address and data one cycle later. Requester 0 is the pipeline and normally wins. An aging counter guarantees that every other requester is eventually granted.

---
 rtl/wb_arbiter_pkg.sv | 23 ++
 rtl/wb_arbiter_rr_pick.sv | 37 +++
 rtl/wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package wb_defs;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Writes to register 0 are accepted but never reach the register file.
  localparam int ZERO_REG = 0;

  // The pipeline writeback stage is always requester 0.
  localparam int WB_PIPE = 0;

  // Wait counters are wide enough for the largest MAX_WAIT (255).
  localparam int WAIT_W = 8;

  // Returns the rotation offset that follows a grant to requester 'win' (1..n_req-1).
  // The round-robin pointer covers requesters 1..n_req-1 and is stored as an offset
  // from requester 1. The next search starts at win+1, which wraps from n_req-1 back to 1.
  function automatic int rr_after(input int win, input int n_req);
    return (win >= n_req - 1) ? 0 : win;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Rotating priority encoder: grants the first set request at or after i_ptr, wrapping around.
module rr_pick #(
  parameter int W  = 3,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [W-1:0]  o_grant,
  output logic          o_found
);

  logic [W-1:0]  w_grant;
  logic          w_found;
  logic [PW-1:0] w_sel;
  int            w_idx;

  // Walk the request vector starting at the pointer; the first hit wins.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int k = 0; k < W; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= W) w_idx = w_idx - W;
      w_sel = w_idx[PW-1:0];
      if (!w_found && i_req[w_sel]) begin
        w_grant[w_sel] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  assign o_grant = w_grant;
  assign o_found = w_found;

endmodule

// File: rtl/wb_arbiter.sv
// Register file write-port arbiter: the pipeline has priority, aging guarantees that
// the other producers make progress, and round-robin shares the remaining slots.
module wb_arbiter
  import wb_defs::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 8,
  localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     hold,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [ID_W-1:0]          grant_id,
  output logic                     aged
);

  localparam int RR_W = N_REQ - 1;
  localparam int RP_W = (RR_W > 1) ? $clog2(RR_W) : 1;

  // r_rr_ptr is an offset from requester 1, so a reset value of 0 means "start at requester 1".
  logic [RP_W-1:0]   r_rr_ptr;
  logic [WAIT_W-1:0] r_wait [1:N_REQ-1];
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [ID_W-1:0]   r_gid;

  logic [N_REQ-1:0]  w_aged_vec;
  logic [N_REQ-1:0]  w_ready;
  logic [RR_W-1:0]   w_rr_grant;
  logic              w_rr_found;
  logic              w_xfer;
  logic              w_win_aged;
  logic [ID_W-1:0]   w_win_id;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;

  // A requester is aged when it is still valid after waiting MAX_WAIT cycles in a row.
  always_comb begin
    w_aged_vec = '0;
    for (int i = 1; i < N_REQ; i++)
      w_aged_vec[i] = req_valid[i] && (r_wait[i] == WAIT_W'(MAX_WAIT));
  end

  rr_pick #(
    .W  (RR_W),
    .PW (RP_W)
  ) u_rr_pick (
    .i_req   (req_valid[N_REQ-1:1]),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_found (w_rr_found)
  );

  // Winner selection: lowest aged requester, then the pipeline, then round-robin.
  // Address and data are kept out of this cone on purpose.
  always_comb begin
    w_ready = '0;
    if (!clr && !hold) begin
      if (|w_aged_vec)
        w_ready = w_aged_vec & (~w_aged_vec + {{(N_REQ-1){1'b0}}, 1'b1});
      else if (req_valid[WB_PIPE])
        w_ready[WB_PIPE] = 1'b1;
      else if (w_rr_found)
        w_ready = {w_rr_grant, 1'b0};
    end
  end

  assign w_xfer     = |w_ready;
  assign w_win_aged = |(w_ready & w_aged_vec);

  // Encode the one-hot grant and mux the winning address and data.
  always_comb begin
    w_win_id   = '0;
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_ready[i]) begin
        w_win_id   = ID_W'(i);
        w_win_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Register the winning write. A register 0 write is accepted but it never raises the enable.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_gid   <= '0;
    end else begin
      r_we <= w_xfer && (w_win_addr != ADDR_W'(ZERO_REG));
      if (w_xfer) begin
        r_waddr <= w_win_addr;
        r_wdata <= w_win_data;
        r_gid   <= w_win_id;
      end
    end
  end

  // Advance the round-robin pointer past any non-pipeline winner, including aged ones.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      r_rr_ptr <= '0;
    else if (w_xfer && (w_win_id != ID_W'(WB_PIPE)))
      r_rr_ptr <= RP_W'(rr_after(int'(w_win_id), N_REQ));
  end

  // Per-requester wait counters. They count every cycle that passes without a transfer,
  // hold cycles included, and saturate at MAX_WAIT.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 1; i < N_REQ; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 1; i < N_REQ; i++) begin
        if (!req_valid[i] || w_ready[i])
          r_wait[i] <= '0;
        else if (r_wait[i] != WAIT_W'(MAX_WAIT))
          r_wait[i] <= r_wait[i] + WAIT_W'(1);
      end
    end
  end

  assign req_ready = w_ready;
  assign aged      = w_win_aged;
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign grant_id  = r_gid;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a rule-level reference model is checked every cycle, and
// directed scenarios add literal expectations on top.
module tb_wb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          clr;
  logic          hold;
  logic [N-1:0]  valid;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] data [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;

  logic [N-1:0]  req_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [1:0]    grant_id;
  logic          aged;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = addr[i];
      req_data[i*DW +: DW] = data[i];
    end
  end

  wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk       (clk),
    .clr       (clr),
    .hold      (hold),
    .req_valid (valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .grant_id  (grant_id),
    .aged      (aged)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: wait counts, pointer and the expected register-file port contents.
  int            m_wait [N];
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_gid;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    m_ptr   = 1;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_gid   = 0;
  endtask

  function automatic int model_winner();
    if (hold) return -1;
    for (int i = 1; i < N; i++)
      if (valid[i] && m_wait[i] >= MW) return i;
    if (valid[0]) return 0;
    for (int k = 0; k < N - 1; k++) begin
      int j;
      j = 1 + (m_ptr - 1 + k) % (N - 1);
      if (valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    w = model_winner();
    if (w >= 0) begin
      m_waddr = addr[w];
      m_wdata = data[w];
      m_gid   = w;
      m_we    = (addr[w] != 0);
      if (w > 0) m_ptr = (w == N - 1) ? 1 : w + 1;
    end else begin
      m_we = 1'b0;
    end
    for (int i = 1; i < N; i++) begin
      if (!valid[i] || w == i) m_wait[i] = 0;
      else if (m_wait[i] < MW) m_wait[i] = m_wait[i] + 1;
    end
  endtask

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin : cmp
    int w;
    logic [N-1:0] er;
    logic ea;
    if (clr) model_reset();
    w  = model_winner();
    er = (!clr && w >= 0) ? (N'(1) << w) : '0;
    ea = !clr && (w >= 1) && (m_wait[w] >= MW);
    chk("m_ready",    req_ready, er);
    chk("m_aged",     aged,      ea);
    chk("m_rf_we",    rf_we,     m_we);
    chk("m_rf_waddr", rf_waddr,  m_waddr);
    chk("m_rf_wdata", rf_wdata,  m_wdata);
    chk("m_grant_id", grant_id,  m_gid);
  end

  always @(posedge clk) if (!clr) model_step();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_on();
    tick();
    clr   = 1'b1;
    valid = '0;
    hold  = 1'b0;
    tick();
  endtask

  task automatic rst_off();
    tick();
    clr = 1'b0;
  endtask

  localparam int NPAT = 8;
  logic [N-1:0] pat_v [NPAT] = '{4'b1111, 4'b0101, 4'b1110, 4'b0000,
                                 4'b1011, 4'b0110, 4'b0111, 4'b1001};
  logic         pat_h [NPAT] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  int           pat_n [NPAT] = '{10, 3, 4, 2, 12, 2, 9, 3};

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr   = 1'b1;
    hold  = 1'b0;
    valid = '1;
    for (int i = 0; i < N; i++) begin
      addr[i] = AW'(i + 1);
      data[i] = 32'h100 + DW'(i);
    end

    // Reset with every requester valid.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  req_ready, 4'b0000);
    chk("rst_we",     rf_we,     1'b0);
    chk("rst_waddr",  rf_waddr,  5'd0);
    chk("rst_wdata",  rf_wdata,  32'd0);
    rst_off();
    @(negedge clk);
    chk("first_grant", req_ready, 4'b0001);

    // Pipeline priority, then aging of requester 1.
    rst_on();
    addr[0] = 5'd3;  data[0] = 32'h0A0;
    addr[1] = 5'd9;  data[1] = 32'h0A1;
    valid = 4'b0011;
    rst_off();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      chk("age_ready", req_ready, (c < 8) ? 4'b0001 : 4'b0010);
      chk("age_flag",  aged,      (c == 8) ? 1'b1 : 1'b0);
      tick();
      if (c == 8) valid = 4'b0001;
    end
    @(negedge clk);
    chk("age_waddr", rf_waddr, 5'd9);
    chk("age_gid",   grant_id, 2'd1);
    chk("age_we",    rf_we,    1'b1);

    // Round-robin among 1..3 with the pipeline idle.
    rst_on();
    addr[1] = 5'd11; addr[2] = 5'd12; addr[3] = 5'd13;
    valid = 4'b1110;
    rst_off();
    for (int c = 0; c < 6; c++) begin
      logic [N-1:0] seq [3];
      seq = '{4'b0010, 4'b0100, 4'b1000};
      @(negedge clk);
      chk("rr_ready", req_ready, seq[c % 3]);
      tick();
      if (c == 5) valid = '0;
    end
    @(negedge clk);
    chk("rr_gid",   grant_id, 2'd3);
    chk("rr_waddr", rf_waddr, 5'd13);

    // Register 0 write is accepted and discarded.
    rst_on();
    addr[2] = 5'd0; data[2] = 32'hDEADBEEF;
    valid = 4'b0100;
    rst_off();
    @(negedge clk);
    chk("r0_ready", req_ready, 4'b0100);
    tick();
    valid = '0;
    @(negedge clk);
    chk("r0_we",    rf_we,    1'b0);
    chk("r0_gid",   grant_id, 2'd2);
    chk("r0_wdata", rf_wdata, 32'hDEADBEEF);

    // Hold blocks grants while the wait counter keeps running.
    rst_on();
    addr[3] = 5'd20; data[3] = 32'h333;
    hold  = 1'b1;
    valid = 4'b1000;
    rst_off();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_ready", req_ready, 4'b0000);
      tick();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold_rel_ready", req_ready, 4'b1000);
    chk("hold_rel_aged",  aged,      1'b0);
    tick();
    hold = 1'b1;
    repeat (10) tick();
    hold = 1'b0;
    @(negedge clk);
    chk("hold_sat_ready", req_ready, 4'b1000);
    chk("hold_sat_aged",  aged,      1'b1);
    tick();
    valid = '0;

    // Reset lands between the transfer edge and the register-file write.
    rst_on();
    addr[1] = 5'd7; data[1] = 32'h55;
    valid = 4'b0010;
    rst_off();
    @(negedge clk);
    chk("mid_ready", req_ready, 4'b0010);
    tick();
    chk("mid_we_before", rf_we, 1'b1);
    clr   = 1'b1;
    valid = '0;
    #1;
    chk("mid_we_async",   rf_we,    1'b0);
    chk("mid_waddr_async", rf_waddr, 5'd0);
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("mid_we_after", rf_we, 1'b0);

    // Mixed traffic checked by the model only, including pipeline writes to register 0.
    rst_on();
    for (int i = 0; i < N; i++) begin
      addr[i] = AW'(i * 5);
      data[i] = 32'hC0DE0000 + DW'(i);
    end
    rst_off();
    for (int p = 0; p < NPAT; p++) begin
      valid = pat_v[p];
      hold  = pat_h[p];
      repeat (pat_n[p]) tick();
    end
    valid = '0;
    hold  = 1'b0;
    repeat (2) tick();

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
